// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin arbiter and command sequencer for a 10-bit-command SPI RAM.
// Ports: clk/rst_n; r0_*/r1_* requester handshakes and responses; rsp_err; ram_* RAM command/data; busy.
module spi_ram_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ready,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_valid,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ready,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              rsp_err,
   output logic [ADDR_W+1:0] ram_din,
   output logic              ram_rx_valid,
   input  logic              ram_tx_valid,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RDW} state_t;

   localparam logic [3:0] LP_TLAST = 4'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_owner;
   logic                r_last;
   logic [3:0]          r_tcnt;
   logic                r_rv0;
   logic                r_rv1;
   logic                r_err;
   logic [DATA_W-1:0]   r_rd0;
   logic [DATA_W-1:0]   r_rd1;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_hs;
   logic                w_tmo;

   // On a tie the requester that was not granted last time wins.
   assign w_gnt0 = r0_valid & (~r1_valid | r_last);
   assign w_gnt1 = r1_valid & (~r0_valid | ~r_last);
   assign w_hs   = r0_ready | r1_ready;
   assign w_tmo  = (r_tcnt == LP_TLAST);

   assign r0_rvalid = r_rv0;
   assign r1_rvalid = r_rv1;
   assign r0_rdata  = r_rd0;
   assign r1_rdata  = r_rd1;
   assign rsp_err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_hs) w_next = S_ADDR;
         S_ADDR:  w_next = S_DATA;
         S_DATA:  w_next = r_we ? S_IDLE : S_RDW;
         S_RDW:   if (ram_tx_valid || w_tmo) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Ready is gated by rst_n so it stays low while reset is held.
   always_comb begin
      ram_rx_valid = 1'b0;
      ram_din      = '0;
      busy         = 1'b1;
      r0_ready     = 1'b0;
      r1_ready     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy     = 1'b0;
            r0_ready = rst_n & w_gnt0;
            r1_ready = rst_n & w_gnt1;
         end
         S_ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = {(r_we ? 2'b00 : 2'b10), r_addr};
         end
         S_DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = r_we ? {2'b01, ADDR_W'(r_wdata)}
                                : {2'b11, {ADDR_W{1'b0}}};
         end
         S_RDW:   ;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_tcnt  <= '0;
         r_rv0   <= 1'b0;
         r_rv1   <= 1'b0;
         r_err   <= 1'b0;
         r_rd0   <= '0;
         r_rd1   <= '0;
      end else begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
         r_err <= 1'b0;
         if (w_hs) begin
            r_we    <= w_gnt0 ? r0_we    : r1_we;
            r_addr  <= w_gnt0 ? r0_addr  : r1_addr;
            r_wdata <= w_gnt0 ? r0_wdata : r1_wdata;
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
            r_tcnt  <= '0;
         end
         if (r_state == S_RDW) begin
            // A timeout returns zero data flagged with rsp_err.
            if (ram_tx_valid || w_tmo) begin
               r_err <= ~ram_tx_valid;
               if (r_owner) begin
                  r_rv1 <= 1'b1;
                  r_rd1 <= ram_tx_valid ? ram_dout : '0;
               end else begin
                  r_rv0 <= 1'b1;
                  r_rd0 <= ram_tx_valid ? ram_dout : '0;
               end
            end else begin
               r_tcnt <= r_tcnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the 10-bit-command SPI RAM (din[9:8] opcode: 00 set write addr, 01 write data, 10 set read addr, 11 read out).
- Converts word-level read/write requests into the RAM's two-command sequences.
- Grants the RAM round-robin, captures read data and returns it to the owning requester.

Parameters:
- ADDR_W, 8, address width; must match RAM address width.
- DATA_W, 8, data width; must match RAM data width.
- TIMEOUT, 4, max cycles in RD_WAIT for ram_tx_valid before error response; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 request valid.
- r0_we  in  1  requester 0: 1=write, 0=read.
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_ready  out  1  requester 0 request accepted this cycle.
- r0_rvalid  out  1  requester 0 read response, 1-cycle pulse.
- r0_rdata  out  DATA_W  requester 0 read data.
- r1_*  same set as r0_*, for requester 1.
- rsp_err  out  1  qualifies rN_rvalid: read timed out, rdata=0.
- ram_din  out  ADDR_W+2  command word to RAM.
- ram_rx_valid  out  1  command strobe to RAM.
- ram_tx_valid  in  1  RAM read-data valid.
- ram_dout  in  DATA_W  RAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE; last_grant=1, so r0 wins first tie; all outputs 0 (ram_din=0, ram_rx_valid=0, rN_ready=0, rN_rvalid=0, rN_rdata=0, rsp_err=0, busy=0); timeout counter=0.
- FSM states: IDLE, ADDR, DATA, RD_WAIT.
- IDLE, arbitration:
  - rN_ready is combinational and high only in IDLE, for the granted requester.
  - Only one requester is granted: sole valid requester wins; if both valid, the one != last_grant wins.
  - Handshake is rN_valid && rN_ready. On handshake, latch we/addr/wdata/owner, update last_grant, go to ADDR.
  - No valid requester: stay in IDLE, ram_rx_valid=0.
- ADDR (1 cycle):
  - ram_rx_valid=1; ram_din = {we ? 2'b00 : 2'b10, addr}.
  - Next state DATA.
- DATA (1 cycle):
  - ram_rx_valid=1.
  - Write: ram_din={2'b01, wdata}; next state IDLE.
  - Read: ram_din={2'b11, 8'h00}; next state RD_WAIT.
- RD_WAIT:
  - ram_rx_valid=0.
  - If ram_tx_valid=1: capture ram_dout, go to IDLE. Owner's rvalid pulses and rdata is updated the cycle after capture; rsp_err=0.
  - The RAM holds tx_valid from a prior read. This is harmless: the 11 command, issued exactly one cycle earlier, guarantees fresh dout in the first RD_WAIT cycle.
  - If ram_tx_valid=0 for TIMEOUT consecutive cycles: go to IDLE. Owner rvalid=1, rdata=0, rsp_err=1, one cycle.
- Latency from handshake cycle T:
  - Write: commands at T+1, T+2; ready for a new grant at T+3.
  - Read: commands at T+1, T+2; capture at T+3; rvalid at T+4; next grant possible at T+4.
- rN_rdata holds its value until that requester's next read response. rvalid and rsp_err are single-cycle pulses.
- Back-to-back requests: arbitration resumes the cycle IDLE is re-entered. No pipelining; one transaction in flight.
- Requester inputs are ignored outside the handshake cycle; changing them mid-transaction has no effect.
- Reset mid-transaction: transaction aborted, no response, ram_rx_valid drops immediately. RAM-side address registers are not restored by this block.
- ram_din=0 whenever ram_rx_valid=0.

Test Plan:
- Reset, r0 write addr=8'h12 data=8'hA5 -> r0_ready at T; ram_din=10'h012 at T+1, 10'h1A5 at T+2 with rx_valid; busy 0 at T+3.
- r1 read addr=8'h12 after the write above -> ram_din=10'h212 at T+1, 10'h300 at T+2; r1_rvalid=1, r1_rdata=8'hA5, rsp_err=0 at T+4.
- r0 and r1 both valid continuously from reset (reads of 8'h05 / 8'h06, RAM initial contents mem[i]=i) -> grants alternate r0,r1,r0,r1; rdata 8'h05 to r0 and 8'h06 to r1; no requester granted twice in a row.
- Read with RAM model holding ram_tx_valid=0 -> after TIMEOUT=4 RD_WAIT cycles, owner rvalid=1, rdata=0, rsp_err=1; FSM back in IDLE.
- Assert rst_n=0 in DATA of a write -> ram_rx_valid=0 asynchronously, no rvalid, busy=0; after release r0 wins first tie.
- r1 alone valid while r0 idle, repeated 3 times -> r1 granted each time; no stall waiting for r0.
